// File: rtl/wb_sram_slave_if.sv
// Wishbone pipelined bus bundle between the two-port arbiter's master side and the SRAM slave.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;
    logic        stall;

    modport master (
        output cyc, stb, we, adr, sel, dat_i,
        input  dat_o, ack, stall
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_i,
        output dat_o, ack, stall
    );
endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone pipelined slave around a byte-writable 32-bit SRAM that is zero-filled after every reset.
// Define WB_SRAM_REG_OUT_EN to add an output register on ack/dat_o (latency becomes LATENCY+1).
module wb_sram_slave #(
    parameter int AWIDTH  = 10,
    parameter int LATENCY = 2
) (
    input logic clk_i,
    input logic rst_i,
    if_wb.slave bus
);
    localparam int                DEPTH     = 1 << AWIDTH;
    localparam logic [AWIDTH-1:0] LAST_WORD = {AWIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_CLEAR,
        S_READY,
        S_FLUSH
    } state_t;

    generate
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $error("wb_sram_slave: LATENCY must be in the range 1..4");
        end
    endgenerate

    state_t             r_state;
    logic [AWIDTH-1:0]  r_clrCnt;
    logic               r_stall;
    logic [31:0]        r_mem [DEPTH];
    logic [LATENCY-1:0] r_vld;
    logic [31:0]        r_dat [LATENCY];

    logic [AWIDTH-1:0]  w_idx;
    logic               w_accept;
    logic               w_inFlight;
    logic               w_flush;
    logic               w_ack;
    logic [31:0]        w_dat;

    // Upper address bits and the byte offset are dropped, so the array aliases across the bus space.
    assign w_idx    = bus.adr[AWIDTH+1:2];
    assign w_accept = (r_state == S_READY) && bus.cyc && bus.stb && !r_stall;
    assign w_flush  = (r_state == S_READY) && !bus.cyc && w_inFlight;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_CLEAR;
            r_clrCnt <= '0;
            r_stall  <= 1'b1;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clrCnt <= r_clrCnt + AWIDTH'(1);
                    if (r_clrCnt == LAST_WORD) begin
                        r_state <= S_READY;
                        r_stall <= 1'b0;
                    end
                end
                S_READY: begin
                    if (w_flush) begin
                        r_state <= S_FLUSH;
                        r_stall <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    r_state <= S_READY;
                    r_stall <= 1'b0;
                end
                default: begin
                    r_state  <= S_CLEAR;
                    r_clrCnt <= '0;
                    r_stall  <= 1'b1;
                end
            endcase
        end
    end

    // The array has no reset of its own; the S_CLEAR sweep is what zero-fills it.
    always_ff @(posedge clk_i) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clrCnt] <= '0;
        end else if (w_accept && bus.we) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.sel[k]) begin
                    r_mem[w_idx][8*k +: 8] <= bus.dat_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            if (w_flush) begin
                r_vld <= '0;
            end else begin
                r_vld[0] <= w_accept;
                for (int i = 1; i < LATENCY; i++) begin
                    r_vld[i] <= r_vld[i-1];
                end
            end
            r_dat[0] <= (w_accept && !bus.we) ? r_mem[w_idx] : '0;
            for (int i = 1; i < LATENCY; i++) begin
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

`ifdef WB_SRAM_REG_OUT_EN
    logic        r_ackOut;
    logic [31:0] r_datOut;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ackOut <= 1'b0;
            r_datOut <= '0;
        end else if (w_flush) begin
            r_ackOut <= 1'b0;
            r_datOut <= '0;
        end else begin
            r_ackOut <= r_vld[LATENCY-1];
            r_datOut <= r_dat[LATENCY-1];
        end
    end

    assign w_inFlight = (|r_vld) || r_ackOut;
    assign w_ack      = r_ackOut && bus.cyc;
    assign w_dat      = r_datOut;
`else
    assign w_inFlight = |r_vld;
    assign w_ack      = r_vld[LATENCY-1] && bus.cyc;
    assign w_dat      = r_dat[LATENCY-1];
`endif

    assign bus.ack   = w_ack;
    assign bus.dat_o = w_ack ? w_dat : '0;
    assign bus.stall = r_stall;
endmodule
